axis_ready_pipeline: RTL and testbench

- AXI-Stream register slice with full-throughput skid-buffer stages; registers both the backward (s_ready) path and the forward (valid/payload) path.
- Breaks long ready-combinational paths between axis_switch ports and distant masters and slaves.
- Sustains one beat per cycle at every stage.
- Optional TDEST, TID and TLAST sidebands travel in lockstep with data.

---
 rtl/axis_ready_pipeline.sv | 127 ++++++++++++
 tb/tb_axis_ready_pipeline.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ready_pipeline.sv
// AXI-Stream register slice built from cascaded skid-buffer stages.
// Both the ready and valid/payload paths are registered at every stage.
module axis_ready_pipeline #(
  parameter int DEPTH      = 1,
  parameter int HAS_DEST   = 0,
  parameter int HAS_ID     = 0,
  parameter int HAS_LAST   = 0,
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [DEST_WIDTH-1:0] s_dest,
  input  logic [ID_WIDTH-1:0]   s_id,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [DEST_WIDTH-1:0] m_dest,
  output logic [ID_WIDTH-1:0]   m_id,
  output logic                  m_last
);

  localparam int PW = DATA_WIDTH + DEST_WIDTH + ID_WIDTH + 1;
  localparam int NL = DEPTH + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Link k sits between stage k-1 and stage k; link 0 is s_*, link DEPTH is m_*.
  logic          link_valid [NL];
  logic          link_ready [NL];
  logic [PW-1:0] link_pay   [NL];

  logic [DEST_WIDTH-1:0] out_dest;
  logic [ID_WIDTH-1:0]   out_id;
  logic                  out_last;
  logic                  unused_sidebands;

  assign link_valid[0] = s_valid;
  assign link_pay[0]   = {s_last, s_id, s_dest, s_data};
  assign s_ready       = link_ready[0];

  assign link_ready[DEPTH] = m_ready;
  assign m_valid           = link_valid[DEPTH];
  assign {out_last, out_id, out_dest, m_data} = link_pay[DEPTH];

  assign m_dest = (HAS_DEST != 0) ? out_dest : '0;
  assign m_id   = (HAS_ID   != 0) ? out_id   : '0;
  assign m_last = (HAS_LAST != 0) ? out_last : 1'b0;

  // Sideband bits are carried through unconditionally and only masked at the output.
  assign unused_sidebands = ^{out_dest, out_id, out_last};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    state_t        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer  = link_valid[k] & in_ready_q;
    assign out_xfer = out_valid_q & link_ready[k+1];

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = link_pay[k];
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = link_pay[k];
          end else if (in_xfer) begin
            skid_d  = link_pay[k];
            state_d = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      // Handshake flags are decodes of the next state so they can be registered.
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        state_q     <= ST_EMPTY;
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        in_ready_q  <= in_ready_d;
        out_valid_q <= out_valid_d;
      end
      main_q <= main_d;
      skid_q <= skid_d;
    end

    assign link_ready[k]   = in_ready_q;
    assign link_valid[k+1] = out_valid_q;
    assign link_pay[k+1]   = main_q;
  end

endmodule

// File: tb/tb_axis_ready_pipeline.sv
// Directed bench for axis_ready_pipeline: four instances covering DEPTH 0..3
// and both sideband configurations, sharing one clock and reset.
module tb_axis_ready_pipeline;

  logic aclk;
  logic aresetn;
  int   n_checks;
  int   n_errors;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // DEPTH=0 passthrough
  logic a0_s_valid, a0_s_ready, a0_m_valid, a0_m_ready, a0_s_last, a0_m_last;
  logic [31:0] a0_s_data, a0_m_data;
  logic [0:0]  a0_s_dest, a0_m_dest, a0_s_id, a0_m_id;
  axis_ready_pipeline #(.DEPTH(0), .DATA_WIDTH(32)) u0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(a0_s_valid), .s_ready(a0_s_ready), .s_data(a0_s_data),
    .s_dest(a0_s_dest), .s_id(a0_s_id), .s_last(a0_s_last),
    .m_valid(a0_m_valid), .m_ready(a0_m_ready), .m_data(a0_m_data),
    .m_dest(a0_m_dest), .m_id(a0_m_id), .m_last(a0_m_last));

  // DEPTH=1
  logic a1_s_valid, a1_s_ready, a1_m_valid, a1_m_ready, a1_s_last, a1_m_last;
  logic [31:0] a1_s_data, a1_m_data;
  logic [0:0]  a1_s_dest, a1_m_dest, a1_s_id, a1_m_id;
  axis_ready_pipeline #(.DEPTH(1), .DATA_WIDTH(32)) u1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(a1_s_valid), .s_ready(a1_s_ready), .s_data(a1_s_data),
    .s_dest(a1_s_dest), .s_id(a1_s_id), .s_last(a1_s_last),
    .m_valid(a1_m_valid), .m_ready(a1_m_ready), .m_data(a1_m_data),
    .m_dest(a1_m_dest), .m_id(a1_m_id), .m_last(a1_m_last));

  // DEPTH=2, sidebands disabled
  logic a2_s_valid, a2_s_ready, a2_m_valid, a2_m_ready, a2_s_last, a2_m_last;
  logic [31:0] a2_s_data, a2_m_data;
  logic [0:0]  a2_s_dest, a2_m_dest, a2_s_id, a2_m_id;
  axis_ready_pipeline #(.DEPTH(2), .DATA_WIDTH(32)) u2 (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(a2_s_valid), .s_ready(a2_s_ready), .s_data(a2_s_data),
    .s_dest(a2_s_dest), .s_id(a2_s_id), .s_last(a2_s_last),
    .m_valid(a2_m_valid), .m_ready(a2_m_ready), .m_data(a2_m_data),
    .m_dest(a2_m_dest), .m_id(a2_m_id), .m_last(a2_m_last));

  // DEPTH=3, all sidebands enabled
  logic a3_s_valid, a3_s_ready, a3_m_valid, a3_m_ready, a3_s_last, a3_m_last;
  logic [31:0] a3_s_data, a3_m_data;
  logic [1:0]  a3_s_dest, a3_m_dest;
  logic [0:0]  a3_s_id, a3_m_id;
  axis_ready_pipeline #(.DEPTH(3), .HAS_DEST(1), .HAS_ID(1), .HAS_LAST(1),
                        .DATA_WIDTH(32), .DEST_WIDTH(2), .ID_WIDTH(1)) u3 (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(a3_s_valid), .s_ready(a3_s_ready), .s_data(a3_s_data),
    .s_dest(a3_s_dest), .s_id(a3_s_id), .s_last(a3_s_last),
    .m_valid(a3_m_valid), .m_ready(a3_m_ready), .m_data(a3_m_data),
    .m_dest(a3_m_dest), .m_id(a3_m_id), .m_last(a3_m_last));

  function automatic logic [35:0] beat3(input int i);
    logic [31:0] d;
    logic [1:0]  dst;
    logic        idb;
    logic        lst;
    d   = 32'h5A00_0000 + i;
    dst = 2'(i % 4);
    idb = 1'(i % 2);
    lst = ((i % 5) == 4);
    return {lst, idb, dst, d};
  endfunction

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int src_idx;
    int rcv;
    int sent;
    int nrx;
    logic acc;
    logic prev_stall;
    logic [35:0] prev_out;
    logic [35:0] cur;

    n_checks = 0;
    n_errors = 0;
    aresetn  = 1'b0;
    {a0_s_valid, a0_m_ready, a0_s_last} = '0; a0_s_data = '0; a0_s_dest = '0; a0_s_id = '0;
    {a1_s_valid, a1_m_ready, a1_s_last} = '0; a1_s_data = '0; a1_s_dest = '0; a1_s_id = '0;
    {a2_s_valid, a2_m_ready, a2_s_last} = '0; a2_s_data = '0; a2_s_dest = '0; a2_s_id = '0;
    {a3_s_valid, a3_m_ready, a3_s_last} = '0; a3_s_data = '0; a3_s_dest = '0; a3_s_id = '0;

    // Reset state
    repeat (3) next_cycle();
    @(negedge aclk);
    chk("rst_sready_d1", a1_s_ready, 0);
    chk("rst_mvalid_d1", a1_m_valid, 0);
    chk("rst_sready_d2", a2_s_ready, 0);
    chk("rst_sready_d3", a3_s_ready, 0);
    chk("rst_mvalid_d3", a3_m_valid, 0);
    next_cycle();
    aresetn = 1'b1;
    next_cycle();
    @(negedge aclk);
    chk("rel_sready_d1", a1_s_ready, 1);
    chk("rel_sready_d2", a2_s_ready, 1);
    chk("rel_sready_d3", a3_s_ready, 1);
    next_cycle();

    // DEPTH=2 back-to-back throughput, disabled sidebands driven high
    a2_m_ready = 1'b1;
    a2_s_last = 1'b1; a2_s_dest = 1'b1; a2_s_id = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      a2_s_valid = (cyc < 8);
      a2_s_data  = 32'h10 + cyc;
      @(negedge aclk);
      if (cyc < 8) chk("t1_sready", a2_s_ready, 1);
      if (cyc >= 2 && cyc < 10) begin
        chk("t1_mvalid", a2_m_valid, 1);
        chk("t1_mdata", a2_m_data, 32'h10 + cyc - 2);
      end else begin
        chk("t1_mvalid_idle", a2_m_valid, 0);
      end
      chk("t4_sidebands", {a2_m_last, a2_m_dest, a2_m_id}, 0);
      next_cycle();
    end
    a2_s_valid = 1'b0;

    // DEPTH=1 stall: m_ready low for cycles 1..4
    src_idx = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      a1_m_ready = !(cyc >= 1 && cyc <= 4);
      a1_s_valid = (src_idx < 6);
      a1_s_data  = 32'hA0 + src_idx;
      @(negedge aclk);
      if (cyc == 1) chk("t2_sready_pre", a1_s_ready, 1);
      if (cyc == 2) chk("t2_sready_fell", a1_s_ready, 0);
      if (cyc >= 2 && cyc <= 4) begin
        chk("t2_stall_valid", a1_m_valid, 1);
        chk("t2_stall_data", a1_m_data, 32'hA0);
      end
      if (cyc == 4) chk("t2_buffered", src_idx, 2);
      if (a1_s_valid && a1_s_ready) src_idx++;
      if (a1_m_valid && a1_m_ready) begin
        chk("t2_order", a1_m_data, 32'hA0 + rcv);
        rcv++;
      end
      next_cycle();
    end
    a1_s_valid = 1'b0;
    chk("t2_count", rcv, 6);

    // DEPTH=3 random handshakes with sidebands
    sent = 0;
    rcv = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    for (int cyc = 0; cyc < 20000 && rcv < 1000; cyc++) begin
      if (!a3_s_valid && sent < 1000 && $urandom_range(0, 1) == 1) a3_s_valid = 1'b1;
      {a3_s_last, a3_s_id, a3_s_dest, a3_s_data} = beat3(sent);
      a3_m_ready = 1'($urandom_range(0, 1));
      @(negedge aclk);
      cur = {a3_m_last, a3_m_id, a3_m_dest, a3_m_data};
      if (prev_stall) chk("t3_stable", cur, prev_out);
      prev_stall = a3_m_valid & ~a3_m_ready;
      prev_out = cur;
      if (a3_m_valid && a3_m_ready) begin
        chk("t3_beat", cur, beat3(rcv));
        rcv++;
      end
      acc = a3_s_valid & a3_s_ready;
      next_cycle();
      if (acc) begin
        sent++;
        a3_s_valid = 1'b0;
      end
    end
    a3_s_valid = 1'b0;
    chk("t3_count", rcv, 1000);

    // DEPTH=2 fill, then reset mid-packet
    a2_m_ready = 1'b0;
    src_idx = 0;
    for (int cyc = 0; cyc < 20 && src_idx < 4; cyc++) begin
      a2_s_valid = 1'b1;
      a2_s_data  = src_idx + 1;
      @(negedge aclk);
      acc = a2_s_valid & a2_s_ready;
      next_cycle();
      if (acc) src_idx++;
    end
    a2_s_valid = 1'b0;
    chk("t5_filled", src_idx, 4);
    @(negedge aclk);
    chk("t5_full_sready", a2_s_ready, 0);
    chk("t5_full_mdata", a2_m_data, 32'h1);
    next_cycle();
    aresetn = 1'b0;
    next_cycle();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("t5_rst_mvalid", a2_m_valid, 0);
    chk("t5_rst_sready", a2_s_ready, 0);
    next_cycle();
    @(negedge aclk);
    chk("t5_rel_sready", a2_s_ready, 1);
    chk("t5_rel_mvalid", a2_m_valid, 0);
    next_cycle();
    a2_m_ready = 1'b1;
    nrx = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      a2_s_valid = (cyc == 0);
      a2_s_data  = 32'h99;
      @(negedge aclk);
      if (a2_m_valid && a2_m_ready) begin
        if (nrx == 0) chk("t5_first_beat", a2_m_data, 32'h99);
        nrx++;
      end
      next_cycle();
    end
    a2_s_valid = 1'b0;
    chk("t5_beat_count", nrx, 1);

    // DEPTH=0 combinational passthrough
    a0_s_valid = 1'b1;
    a0_s_data  = 32'hDEADBEEF;
    a0_s_last  = 1'b1;
    a0_m_ready = 1'b0;
    #1;
    chk("t6_sready_lo", a0_s_ready, 0);
    chk("t6_mvalid", a0_m_valid, 1);
    chk("t6_mdata", a0_m_data, 32'hDEADBEEF);
    chk("t6_sidebands", {a0_m_last, a0_m_dest, a0_m_id}, 0);
    a0_m_ready = 1'b1;
    #1;
    chk("t6_sready_hi", a0_s_ready, 1);
    a0_s_valid = 1'b0;
    #1;
    chk("t6_mvalid_lo", a0_m_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
